// File: rtl/rf_pkg.sv
// Shared defaults, address type and flat-bus helper for the scoreboarded register file.
package rf_pkg;
    localparam int RF_WIDTH  = 16;
    localparam int RF_NREGS  = 8;
    localparam int RF_PEND_W = 2;
    localparam int RF_AW     = $clog2(RF_NREGS);

    typedef logic [RF_AW-1:0] reg_addr_t;

    // Low bit of register idx within the flat all-register image.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction
endpackage

// File: rtl/rf_pend_ctr.sv
// Saturating pending-write counter for one register; inc and dec in the same cycle cancel.
// Count updates one cycle after the request; never wraps in either direction.
module rf_pend_ctr #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt,
    output logic              nonzero,
    output logic              full
);
    logic [PEND_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && !dec && r_cnt != '1) begin
            r_cnt <= r_cnt + PEND_W'(1);
        end else if (dec && !inc && r_cnt != '0) begin
            r_cnt <= r_cnt - PEND_W'(1);
        end
    end

    assign cnt     = r_cnt;
    assign nonzero = (r_cnt != '0);
    assign full    = (r_cnt == '1);
endmodule

// File: rtl/rf_scoreboard.sv
// Register file with one write port, two combinational read ports and a per-register
// pending-write scoreboard the issue stage uses to detect RAW hazards.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int  WIDTH   = RF_WIDTH,
    parameter int  NREGS   = RF_NREGS,
    parameter int  PEND_W  = RF_PEND_W,
    parameter bit  BYPASS  = 1'b1,
    parameter bit  ZERO_R0 = 1'b0,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [AW-1:0]          raddr_a,
    input  logic [AW-1:0]          raddr_b,
    output logic [WIDTH-1:0]       rdata_a,
    output logic [WIDTH-1:0]       rdata_b,
    output logic                   busy_a,
    output logic                   busy_b,
    input  logic                   rsv_valid,
    input  logic [AW-1:0]          rsv_addr,
    output logic                   rsv_ready,
    output logic [NREGS-1:0]       busy_vec,
    output logic [NREGS*WIDTH-1:0] out_rf
);
    logic [WIDTH-1:0]  r_regs [NREGS];
    logic [PEND_W-1:0] w_cnt  [NREGS];
    logic [NREGS-1:0]  w_inc;
    logic [NREGS-1:0]  w_dec;
    logic [NREGS-1:0]  w_nz;
    logic [NREGS-1:0]  w_full;
    logic              w_wr_ok;
    logic              w_rsv_acc;

    assign w_wr_ok = we && !(ZERO_R0 && waddr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[waddr] <= wdata;
        end
    end

    // A retiring write on the reserved register frees a slot in the same cycle.
    assign rsv_ready = !w_full[rsv_addr] || w_dec[rsv_addr];
    assign w_rsv_acc = rsv_valid && rsv_ready;

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        localparam bit HARD_ZERO = ZERO_R0 && (i == 0);

        assign w_inc[i] = w_rsv_acc && (rsv_addr == AW'(i)) && !HARD_ZERO;
        assign w_dec[i] = we && (waddr == AW'(i)) && (w_cnt[i] != '0);

        rf_pend_ctr #(
            .PEND_W (PEND_W)
        ) u_ctr (
            .clk     (clk),
            .rst     (rst),
            .inc     (w_inc[i]),
            .dec     (w_dec[i]),
            .cnt     (w_cnt[i]),
            .nonzero (w_nz[i]),
            .full    (w_full[i])
        );

        assign out_rf[slice_lo(i, WIDTH) +: WIDTH] = HARD_ZERO ? '0 : r_regs[i];
    end

    assign busy_vec = w_nz;
    assign busy_a   = w_nz[raddr_a];
    assign busy_b   = w_nz[raddr_b];

    always_comb begin
        rdata_a = r_regs[raddr_a];
        if (BYPASS && w_wr_ok && waddr == raddr_a) begin
            rdata_a = wdata;
        end
        if (ZERO_R0 && raddr_a == '0) begin
            rdata_a = '0;
        end
    end

    always_comb begin
        rdata_b = r_regs[raddr_b];
        if (BYPASS && w_wr_ok && waddr == raddr_b) begin
            rdata_b = wdata;
        end
        if (ZERO_R0 && raddr_b == '0) begin
            rdata_b = '0;
        end
    end
endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: three configurations (bypass, no bypass, hardwired R0) share
// one stimulus stream, checked against a table of known cycles and an array-based model.
module tb_rf_scoreboard;
    import rf_pkg::*;

    localparam int W    = 16;
    localparam int N    = 8;
    localparam int CMAX = 3;
    localparam int NCFG = 3;
    typedef logic [127:0] cw_t;

    localparam bit BYP [NCFG] = '{1'b1, 1'b0, 1'b1};
    localparam bit ZR  [NCFG] = '{1'b0, 1'b0, 1'b1};

    logic           clk = 1'b0;
    logic           rst;
    logic           we;
    reg_addr_t      waddr;
    logic [W-1:0]   wdata;
    reg_addr_t      raddr_a;
    reg_addr_t      raddr_b;
    logic           rsv_valid;
    reg_addr_t      rsv_addr;

    logic [W-1:0]   rda [NCFG];
    logic [W-1:0]   rdb [NCFG];
    logic           ba  [NCFG];
    logic           bb  [NCFG];
    logic           rr  [NCFG];
    logic [N-1:0]   bv  [NCFG];
    logic [N*W-1:0] orf [NCFG];

    logic [W-1:0]   m_regs [NCFG][N];
    int             m_cnt  [NCFG][N];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_scoreboard #(.WIDTH(W), .NREGS(N), .PEND_W(2), .BYPASS(1'b1), .ZERO_R0(1'b0)) u_dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda[0]), .rdata_b(rdb[0]),
        .busy_a(ba[0]), .busy_b(bb[0]), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .rsv_ready(rr[0]), .busy_vec(bv[0]), .out_rf(orf[0]));

    rf_scoreboard #(.WIDTH(W), .NREGS(N), .PEND_W(2), .BYPASS(1'b0), .ZERO_R0(1'b0)) u_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda[1]), .rdata_b(rdb[1]),
        .busy_a(ba[1]), .busy_b(bb[1]), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .rsv_ready(rr[1]), .busy_vec(bv[1]), .out_rf(orf[1]));

    rf_scoreboard #(.WIDTH(W), .NREGS(N), .PEND_W(2), .BYPASS(1'b1), .ZERO_R0(1'b1)) u_z (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda[2]), .rdata_b(rdb[2]),
        .busy_a(ba[2]), .busy_b(bb[2]), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .rsv_ready(rr[2]), .busy_vec(bv[2]), .out_rf(orf[2]));

    task automatic chk(input string nm, input cw_t act, input cw_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int c = 0; c < NCFG; c++) begin
            for (int i = 0; i < N; i++) begin
                m_regs[c][i] = '0;
                m_cnt[c][i]  = 0;
            end
        end
    endtask

    function automatic logic [W-1:0] exp_rd(input int c, input reg_addr_t ra);
        if (ZR[c] && ra == 0) return '0;
        if (BYP[c] && we && waddr == ra && !(ZR[c] && waddr == 0)) return wdata;
        return m_regs[c][ra];
    endfunction

    function automatic logic exp_ready(input int c);
        return (m_cnt[c][rsv_addr] != CMAX) ||
               (we && waddr == rsv_addr && m_cnt[c][waddr] != 0);
    endfunction

    function automatic logic [N-1:0] exp_bv(input int c);
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) b[i] = (m_cnt[c][i] != 0);
        return b;
    endfunction

    function automatic logic [N*W-1:0] exp_orf(input int c);
        logic [N*W-1:0] f;
        for (int i = 0; i < N; i++) f[i*W +: W] = m_regs[c][i];
        return f;
    endfunction

    task automatic model_step();
        for (int c = 0; c < NCFG; c++) begin
            bit acc, inc, dec;
            acc = rsv_valid && exp_ready(c);
            inc = acc && !(ZR[c] && rsv_addr == 0);
            dec = we && m_cnt[c][waddr] != 0;
            if (dec) m_cnt[c][waddr]--;
            if (inc) m_cnt[c][rsv_addr]++;
            if (we && !(ZR[c] && waddr == 0)) m_regs[c][waddr] = wdata;
        end
    endtask

    task automatic check_model(input string tag);
        for (int c = 0; c < NCFG; c++) begin
            chk($sformatf("%s cfg%0d rdata_a", tag, c), cw_t'(rda[c]), cw_t'(exp_rd(c, raddr_a)));
            chk($sformatf("%s cfg%0d rdata_b", tag, c), cw_t'(rdb[c]), cw_t'(exp_rd(c, raddr_b)));
            chk($sformatf("%s cfg%0d busy_a", tag, c), cw_t'(ba[c]), cw_t'(m_cnt[c][raddr_a] != 0));
            chk($sformatf("%s cfg%0d busy_b", tag, c), cw_t'(bb[c]), cw_t'(m_cnt[c][raddr_b] != 0));
            chk($sformatf("%s cfg%0d rsv_ready", tag, c), cw_t'(rr[c]), cw_t'(exp_ready(c)));
            chk($sformatf("%s cfg%0d busy_vec", tag, c), cw_t'(bv[c]), cw_t'(exp_bv(c)));
            chk($sformatf("%s cfg%0d out_rf", tag, c), cw_t'(orf[c]), cw_t'(exp_orf(c)));
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic         we;
        reg_addr_t    wa;
        logic [W-1:0] wd;
        reg_addr_t    ra;
        reg_addr_t    rb;
        logic         rv;
        reg_addr_t    rsa;
        logic [W-1:0] e_rda;     // bypass config
        logic [W-1:0] e_rda_nb;  // no-bypass config
        logic [N-1:0] e_bv;
        logic         e_rdy;
        logic         e_bb;
    } vec_t;

    vec_t tbl [18];

    initial begin
        tbl[0]  = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd0, 1'b0, 3'd5, 16'hBEEF, 16'h0000, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 3'd3, 16'h0000, 3'd3, 3'd0, 1'b0, 3'd5, 16'hBEEF, 16'hBEEF, 8'h00, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd0, 1'b1, 3'd5, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd0, 1'b1, 3'd5, 16'h0000, 16'h0000, 8'h20, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd0, 1'b1, 3'd5, 16'h0000, 16'h0000, 8'h20, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd0, 1'b1, 3'd5, 16'h0000, 16'h0000, 8'h20, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 3'd5, 16'h0005, 3'd5, 3'd0, 1'b0, 3'd5, 16'h0005, 16'h0000, 8'h20, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 3'd5, 16'h0055, 3'd5, 3'd0, 1'b0, 3'd5, 16'h0055, 16'h0005, 8'h20, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 3'd5, 16'h0555, 3'd5, 3'd0, 1'b0, 3'd5, 16'h0555, 16'h0055, 8'h20, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 3'd5, 16'h0000, 3'd5, 3'd0, 1'b0, 3'd5, 16'h0555, 16'h0555, 8'h00, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, 1'b1, 3'd2, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 3'd2, 16'h2222, 3'd2, 3'd2, 1'b1, 3'd2, 16'h2222, 16'h0000, 8'h04, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 3'd2, 16'h0000, 3'd2, 3'd2, 1'b1, 3'd2, 16'h2222, 16'h2222, 8'h04, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, 1'b1, 3'd2, 16'h2222, 16'h2222, 8'h04, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 3'd2, 16'h3333, 3'd2, 3'd2, 1'b1, 3'd2, 16'h3333, 16'h2222, 8'h04, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, 1'b0, 3'd2, 16'h3333, 16'h3333, 8'h04, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 3'd6, 16'h1234, 3'd6, 3'd2, 1'b0, 3'd2, 16'h1234, 16'h0000, 8'h04, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 3'd0, 16'h0000, 3'd6, 3'd2, 1'b0, 3'd2, 16'h1234, 16'h1234, 8'h04, 1'b0, 1'b1};

        // Reset state
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0; rsv_valid = 1'b0; rsv_addr = '0;
        model_reset();
        #1;
        chk("reset busy_vec", cw_t'(bv[0]), cw_t'(8'h00));
        chk("reset rsv_ready", cw_t'(rr[0]), cw_t'(1'b1));
        chk("reset out_rf", cw_t'(orf[0]), cw_t'(0));
        check_model("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            we = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd;
            raddr_a = tbl[i].ra; raddr_b = tbl[i].rb;
            rsv_valid = tbl[i].rv; rsv_addr = tbl[i].rsa;
            #1;
            chk($sformatf("tbl%0d rdata_a", i), cw_t'(rda[0]), cw_t'(tbl[i].e_rda));
            chk($sformatf("tbl%0d nobyp rdata_a", i), cw_t'(rda[1]), cw_t'(tbl[i].e_rda_nb));
            chk($sformatf("tbl%0d busy_vec", i), cw_t'(bv[0]), cw_t'(tbl[i].e_bv));
            chk($sformatf("tbl%0d rsv_ready", i), cw_t'(rr[0]), cw_t'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d busy_b", i), cw_t'(bb[0]), cw_t'(tbl[i].e_bb));
            check_model($sformatf("tbl%0d", i));
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
        chk("out_rf R3 slice", cw_t'(orf[0][63:48]), cw_t'(16'hBEEF));

        // Asynchronous reset with pending counts, checked before any clock edge
        we = 1'b0; rsv_valid = 1'b0; raddr_a = 3'd3; rsv_addr = 3'd2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst out_rf", cw_t'(orf[0]), cw_t'(0));
        chk("midrst busy_vec", cw_t'(bv[0]), cw_t'(8'h00));
        chk("midrst rsv_ready", cw_t'(rr[0]), cw_t'(1'b1));
        check_model("midrst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Hardwired R0: write and reserve are both ignored
        we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; raddr_a = 3'd0; raddr_b = 3'd0;
        #1;
        chk("zr0 bypass rdata_a", cw_t'(rda[2]), cw_t'(16'h0000));
        check_model("zr0 write");
        @(posedge clk); model_step(); @(negedge clk);
        we = 1'b0; rsv_valid = 1'b1; rsv_addr = 3'd0;
        #1;
        chk("zr0 out_rf r0", cw_t'(orf[2][15:0]), cw_t'(16'h0000));
        chk("zr0 rdata_a", cw_t'(rda[2]), cw_t'(16'h0000));
        check_model("zr0 rsv");
        @(posedge clk); model_step(); @(negedge clk);
        rsv_valid = 1'b0;
        #1;
        chk("zr0 busy r0", cw_t'(bv[2][0]), cw_t'(1'b0));
        chk("zr0 rsv_ready", cw_t'(rr[2]), cw_t'(1'b1));
        chk("r0 busy without zero", cw_t'(bv[0][0]), cw_t'(1'b1));
        check_model("zr0 after");
        @(posedge clk); model_step(); @(negedge clk);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            rst       = ($urandom_range(0, 149) == 0);
            we        = $urandom_range(0, 1);
            waddr     = reg_addr_t'($urandom_range(0, N - 1));
            wdata     = W'($urandom);
            raddr_a   = reg_addr_t'($urandom_range(0, N - 1));
            raddr_b   = reg_addr_t'($urandom_range(0, N - 1));
            rsv_valid = ($urandom_range(0, 9) < 6);
            rsv_addr  = reg_addr_t'($urandom_range(0, N - 1));
            if (rst) model_reset();
            #1;
            check_model($sformatf("rnd%0d", k));
            @(posedge clk);
            if (!rst) model_step();
            @(negedge clk);
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
